// File: rtl/madd_sched.sv
// madd_sched: shares one madd engine between NUM_REQ requesters.
// A round-robin arbiter picks one job owner; each job runs NSPLIT+1
// engine passes (idx_split 0..NSPLIT). Every pass is guarded by a watchdog.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// CHK   | owner granted; wait until the engine reports idle
// ISSUE | single-cycle start pulse for the current pass
// ARM   | engine has not yet dropped done; ignore it for one cycle
// WAIT  | pass in flight; watch done and the watchdog
// FIN   | job_done pulse to the owner, release the grant
module madd_sched #(
    parameter int NUM_REQ     = 2,
    parameter int WDOG_W      = 14,
    parameter int WDOG_CYCLES = 12000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [2*NUM_REQ-1:0]   i_req_nsplit,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_job_done,
    output logic                   o_job_err,
    output logic                   o_madd_start,
    input  logic                   i_madd_done,
    output logic [1:0]             o_idx_split,
    output logic                   o_busy,
    output logic                   o_err_sticky
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_FIN
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [1:0]         nsplit_q;
    logic [1:0]         pass_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic               err_q;
    logic               sticky_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [1:0]         win_nsplit;

    // Round-robin pick: first pending request after rr_ptr, wrapping around.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_nsplit = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && i_req[j] && (((int'(rr_ptr_q) + i) % NUM_REQ) == j)) begin
                    win_found  = 1'b1;
                    win_idx    = IDX_W'(j);
                    win_nsplit = i_req_nsplit[2*j +: 2];
                end
            end
        end
    end

    // Job sequencer: grant, per-pass start/wait handshake, watchdog, release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            owner_q  <= '0;
            nsplit_q <= '0;
            pass_q   <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        owner_q  <= win_idx;
                        nsplit_q <= win_nsplit;
                        pass_q   <= '0;
                        gnt_q    <= NUM_REQ'(1) << win_idx;
                        state_q  <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (i_madd_done) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= ST_ARM;
                end
                ST_ARM: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done has priority over a same-cycle watchdog expiry.
                    if (i_madd_done) begin
                        if (pass_q == nsplit_q) begin
                            state_q <= ST_FIN;
                        end else begin
                            pass_q  <= pass_q + 2'd1;
                            state_q <= ST_ISSUE;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        sticky_q <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= ST_FIN;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_FIN: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= owner_q;
                    err_q    <= 1'b0;
                    pass_q   <= '0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = gnt_q;
    assign o_madd_start = (state_q == ST_ISSUE);
    assign o_job_done   = (state_q == ST_FIN) ? gnt_q : '0;
    assign o_job_err    = (state_q == ST_FIN) && err_q;
    assign o_idx_split  = pass_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_madd_sched.sv
// Bench for madd_sched: behavioural madd_top model, directed job table,
// hand-written wait/reset sequences and a randomized round-robin phase.
module tb_madd_sched;

    localparam int NUM_REQ = 2;
    localparam int WDOG    = 50;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   i_req = '0;
    logic [2*NUM_REQ-1:0] i_req_nsplit = '0;
    logic [NUM_REQ-1:0]   o_gnt;
    logic [NUM_REQ-1:0]   o_job_done;
    logic                 o_job_err;
    logic                 o_madd_start;
    logic                 i_madd_done = 1'b1;
    logic [1:0]           o_idx_split;
    logic                 o_busy;
    logic                 o_err_sticky;

    madd_sched #(
        .NUM_REQ    (NUM_REQ),
        .WDOG_W     (14),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_req_nsplit(i_req_nsplit),
        .o_gnt       (o_gnt),
        .o_job_done  (o_job_done),
        .o_job_err   (o_job_err),
        .o_madd_start(o_madd_start),
        .i_madd_done (i_madd_done),
        .o_idx_split (o_idx_split),
        .o_busy      (o_busy),
        .o_err_sticky(o_err_sticky)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // madd_top model: done low for busy_len cycles starting the cycle after start.
    int   busy_left = 0;
    int   set_busy = -1;
    int   busy_len = 20;
    bit   eng_hang = 1'b0;
    logic start_smp = 1'b0;
    always @(negedge clk) start_smp = o_madd_start;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (set_busy >= 0) begin
                busy_left = set_busy;
                set_busy  = -1;
            end else if (start_smp) begin
                busy_left = eng_hang ? 1000000 : busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            i_madd_done = (busy_left == 0);
        end
    end

    // Reference state: round-robin pointer and sticky error expectation.
    int exp_rr = NUM_REQ - 1;
    bit exp_sticky = 1'b0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int rr);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = (rr + i) % NUM_REQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Always-on protocol checks: grant one-hot-or-zero, no start on a busy engine.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ($countones(o_gnt) > 1) begin
                n_fail++;
                $display("FAIL gnt_onehot: got %b expected at most one bit", o_gnt);
            end
            n_cmp++;
            if (o_madd_start && !i_madd_done) begin
                n_fail++;
                $display("FAIL start_while_busy: got start=1 done=0 expected no start");
            end
        end
    end

    task automatic wait_done(input string tag);
        int bound;
        bound = 0;
        while (i_madd_done !== 1'b1 && bound < 500) begin
            chk({tag, "_nostart"}, o_madd_start, 0);
            step();
            bound++;
        end
        if (bound >= 500) fail_now({tag, "_done_wait"});
    endtask

    // One full job: called at the negedge of an IDLE cycle in which the
    // requests have just been set up; returns one cycle after job_done.
    task automatic serve(input int who, input int ns, input bit hang, input string tag);
        logic [NUM_REQ-1:0] oh;
        int bound;
        int s;
        bit timed_out;
        oh = '0;
        oh[who] = 1'b1;
        timed_out = 1'b0;
        step();
        chk({tag, "_gnt"}, o_gnt, oh);
        chk({tag, "_busy"}, o_busy, 1);
        for (int p = 0; p <= ns; p++) begin
            wait_done(tag);
            step();
            chk({tag, "_start"}, o_madd_start, 1);
            chk({tag, "_idx"}, o_idx_split, p);
            s = cyc;
            step();
            step();
            if (hang) begin
                bound = 0;
                while (o_job_done === '0 && bound < 200) begin
                    step();
                    bound++;
                end
                chk({tag, "_timeout_lat"}, cyc - s, WDOG + 2);
                timed_out = 1'b1;
                break;
            end
        end
        if (!timed_out) begin
            wait_done(tag);
            step();
        end
        if (hang) exp_sticky = 1'b1;
        chk({tag, "_job_done"}, o_job_done, oh);
        chk({tag, "_job_err"}, o_job_err, hang);
        chk({tag, "_sticky"}, o_err_sticky, exp_sticky);
        chk({tag, "_gnt_fin"}, o_gnt, oh);
        i_req[who] = 1'b0;
        exp_rr = who;
        if (hang) set_busy = 0;
        step();
        chk({tag, "_done_clr"}, o_job_done, 0);
        chk({tag, "_gnt_clr"}, o_gnt, 0);
        chk({tag, "_idle"}, o_busy, 0);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] ns0;
        logic [1:0] ns1;
        int         busy;
        bit         hang;
        int         who;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int bound;
        int who;
        int ns;
        logic [1:0] m;

        tbl[0] = '{2'b01, 2'd0, 2'd0, 20, 1'b0, 0};
        tbl[1] = '{2'b10, 2'd0, 2'd3, 20, 1'b0, 1};
        tbl[2] = '{2'b11, 2'd1, 2'd2, 20, 1'b0, 0};
        tbl[3] = '{2'b10, 2'd1, 2'd2, 20, 1'b0, 1};
        tbl[4] = '{2'b11, 2'd2, 2'd0, 7,  1'b0, 0};
        tbl[5] = '{2'b10, 2'd2, 2'd0, 7,  1'b0, 1};
        tbl[6] = '{2'b01, 2'd1, 2'd0, 20, 1'b1, 0};
        tbl[7] = '{2'b10, 2'd0, 2'd1, 5,  1'b0, 1};

        // Reset state
        step();
        step();
        step();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_job_done", o_job_done, 0);
        chk("rst_job_err", o_job_err, 0);
        chk("rst_start", o_madd_start, 0);
        chk("rst_idx", o_idx_split, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sticky", o_err_sticky, 0);
        rst_n = 1'b1;
        step();

        // Directed job table
        for (int r = 0; r < 8; r++) begin
            i_req_nsplit = {tbl[r].ns1, tbl[r].ns0};
            busy_len = tbl[r].busy;
            eng_hang = tbl[r].hang;
            i_req = i_req | tbl[r].req;
            serve(tbl[r].who,
                  (tbl[r].who == 0) ? int'(tbl[r].ns0) : int'(tbl[r].ns1),
                  tbl[r].hang, $sformatf("vec%0d", r));
        end

        // Engine still busy at arbitration: hold in CHK until done returns.
        eng_hang = 1'b0;
        busy_len = 20;
        set_busy = 10;
        step();
        chk("t5_engine_busy", i_madd_done, 0);
        i_req_nsplit = {2'd0, 2'd0};
        i_req = 2'b01;
        serve(0, 0, 1'b0, "t5");

        // Reset during WAIT of pass 2 aborts silently.
        i_req_nsplit = {2'd0, 2'd3};
        i_req = 2'b01;
        bound = 0;
        while (!(o_madd_start === 1'b1 && o_idx_split === 2'd2) && bound < 500) begin
            step();
            bound++;
        end
        if (bound >= 500) fail_now("t6_reach_pass2");
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("t6_gnt", o_gnt, 0);
        chk("t6_job_done", o_job_done, 0);
        chk("t6_job_err", o_job_err, 0);
        chk("t6_start", o_madd_start, 0);
        chk("t6_idx", o_idx_split, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_sticky", o_err_sticky, 0);
        rst_n = 1'b1;
        i_req = '0;
        set_busy = 0;
        exp_rr = NUM_REQ - 1;
        exp_sticky = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_job_done", o_job_done, 0);
            chk("t6_idle", o_busy, 0);
        end
        i_req_nsplit = {2'd0, 2'd1};
        i_req = 2'b01;
        serve(0, 1, 1'b0, "t6_fresh");

        // Randomized jobs against the round-robin reference.
        for (int k = 0; k < 40; k++) begin
            m = 2'($urandom_range(1, 3));
            i_req_nsplit = 4'($urandom_range(0, 15));
            busy_len = $urandom_range(1, 30);
            eng_hang = 1'b0;
            i_req = i_req | m;
            who = rr_pick(i_req, exp_rr);
            ns = (who == 0) ? int'(i_req_nsplit[1:0]) : int'(i_req_nsplit[3:2]);
            serve(who, ns, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
